// File: rtl/phase_pkg.sv
// Shared definitions for the phase_a sequencer: default widths and FSM state encoding.
package phase_pkg;

    localparam int unsigned SIZE_DEF  = 3072;
    localparam int unsigned RADIX_DEF = 32;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LAUNCH = 3'd1;
    localparam logic [2:0] S_WAIT   = 3'd2;
    localparam logic [2:0] S_GAP    = 3'd3;
    localparam logic [2:0] S_DONE   = 3'd4;

    typedef enum logic [2:0] {
        StIdle   = S_IDLE,
        StLaunch = S_LAUNCH,
        StWait   = S_WAIT,
        StGap    = S_GAP,
        StDone   = S_DONE
    } state_e;

endpackage

// File: rtl/phase_watchdog.sv
// Saturating wait-cycle counter; expire_o flags that the count has reached Timeout.
module phase_watchdog #(
    parameter int unsigned Timeout = 63,
    parameter int unsigned ToW     = 6
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic en_i,
    output logic expire_o
);

    logic [ToW-1:0] cnt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clear_i) begin
            cnt_q <= '0;
        end else if (en_i && (cnt_q != ToW'(Timeout))) begin
            cnt_q <= cnt_q + ToW'(1);
        end
    end

    assign expire_o = (cnt_q == ToW'(Timeout));

endmodule

// File: rtl/phase_a_sequencer.sv
// Drives iterated phase_a rounds: launch, wait for completion, feed result back, report.
module phase_a_sequencer
    import phase_pkg::*;
#(
    parameter int unsigned SIZE    = SIZE_DEF,
    parameter int unsigned ROUND_W = 8,
    parameter int unsigned TIMEOUT = 63,
    parameter int unsigned TO_W    = $clog2(TIMEOUT + 1)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [SIZE-1:0]    a_in,
    input  logic [ROUND_W-1:0] rounds,
    output logic               ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [SIZE-1:0]    res_a,
    output logic               res_err,
    output logic [SIZE-1:0]    pa_a,
    output logic               pa_en,
    input  logic [SIZE-1:0]    pa_new_a,
    input  logic               pa_en_out
);

    state_e             state_q;
    logic               ready_q;
    logic               pa_en_q;
    logic [SIZE-1:0]    pa_a_q;
    logic               res_valid_q;
    logic [SIZE-1:0]    res_a_q;
    logic               res_err_q;
    logic [ROUND_W-1:0] rem_q;
    logic               wd_expire;

    phase_watchdog #(
        .Timeout (TIMEOUT),
        .ToW     (TO_W)
    ) u_watchdog (
        .clk_i    (clk),
        .rst_i    (rst),
        .clear_i  (state_q == StLaunch),
        .en_i     (state_q == StWait),
        .expire_o (wd_expire)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ready_q     <= 1'b1;
            pa_en_q     <= 1'b0;
            pa_a_q      <= '0;
            res_valid_q <= 1'b0;
            res_a_q     <= '0;
            res_err_q   <= 1'b0;
            rem_q       <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start && ready_q) begin
                        // res_a preloaded so a timeout before any capture reports a_in
                        pa_a_q    <= a_in;
                        res_a_q   <= a_in;
                        res_err_q <= 1'b0;
                        rem_q     <= rounds;
                        ready_q   <= 1'b0;
                        if (rounds == '0) begin
                            state_q     <= StDone;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= StLaunch;
                            pa_en_q <= 1'b1;
                        end
                    end
                end
                StLaunch: begin
                    pa_en_q <= 1'b0;
                    state_q <= StWait;
                end
                StWait: begin
                    if (pa_en_out) begin
                        pa_a_q  <= pa_new_a;
                        res_a_q <= pa_new_a;
                        rem_q   <= rem_q - ROUND_W'(1);
                        if (rem_q == ROUND_W'(1)) begin
                            state_q     <= StDone;
                            res_valid_q <= 1'b1;
                        end else begin
                            state_q <= StGap;
                        end
                    end else if (wd_expire) begin
                        state_q     <= StDone;
                        res_valid_q <= 1'b1;
                        res_err_q   <= 1'b1;
                    end
                end
                StGap: begin
                    state_q <= StLaunch;
                    pa_en_q <= 1'b1;
                end
                StDone: begin
                    if (res_ready) begin
                        res_valid_q <= 1'b0;
                        ready_q     <= 1'b1;
                        state_q     <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign ready     = ready_q;
    assign pa_en     = pa_en_q;
    assign pa_a      = pa_a_q;
    assign res_valid = res_valid_q;
    assign res_a     = res_a_q;
    assign res_err   = res_err_q;

endmodule

// File: tb/tb_phase_a_sequencer.sv
// Randomized bench for phase_a_sequencer with a behavioural phase_a stand-in and result model.
module tb_phase_a_sequencer;

    localparam int unsigned SIZE    = 3072;
    localparam int unsigned ROUND_W = 8;
    localparam int unsigned TIMEOUT = 63;
    localparam int unsigned TO_W    = 6;
    localparam int          BUDGET  = 2000;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               start = 1'b0;
    logic [SIZE-1:0]    a_in = '0;
    logic [ROUND_W-1:0] rounds = '0;
    logic               ready;
    logic               res_valid;
    logic               res_ready = 1'b0;
    logic [SIZE-1:0]    res_a;
    logic               res_err;
    logic [SIZE-1:0]    pa_a;
    logic               pa_en;
    logic [SIZE-1:0]    pa_new_a;
    logic               pa_en_out;

    int n_vec = 0;
    int n_err = 0;

    phase_a_sequencer #(
        .SIZE    (SIZE),
        .ROUND_W (ROUND_W),
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a_in      (a_in),
        .rounds    (rounds),
        .ready     (ready),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_a     (res_a),
        .res_err   (res_err),
        .pa_a      (pa_a),
        .pa_en     (pa_en),
        .pa_new_a  (pa_new_a),
        .pa_en_out (pa_en_out)
    );

    always #5 clk = ~clk;

    // phase_a stand-in configuration: 0 a+1, 1 a^1, 2 a^key, 3 never completes
    int              mode = 0;
    int              lat = 20;
    logic [SIZE-1:0] key = '0;
    int              launches = 0;
    bit              pulse_bad = 0;
    bit              stab_bad = 0;
    bit              spur_req = 0;

    function automatic logic [SIZE-1:0] rand_wide();
        logic [SIZE-1:0] r;
        for (int i = 0; i < SIZE / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    function automatic logic [SIZE-1:0] f(input logic [SIZE-1:0] a, input int md,
                                          input logic [SIZE-1:0] k);
        case (md)
            0:       return a + SIZE'(1);
            1:       return a ^ SIZE'(1);
            default: return a ^ k;
        endcase
    endfunction

    // Completion pulse arrives lat cycles after the cycle in which pa_en is seen high.
    initial begin : phase_a_model
        int              mcyc;
        int              due;
        bit              pend;
        bit              prev_en;
        logic [SIZE-1:0] resp;
        logic [SIZE-1:0] held;
        mcyc = 0; due = 0; pend = 0; prev_en = 0; resp = '0; held = '0;
        pa_en_out = 1'b0;
        pa_new_a  = '0;
        forever begin
            @(posedge clk); #1;
            mcyc++;
            pa_en_out = 1'b0;
            if (rst) begin
                pend = 0;
                prev_en = 0;
            end else begin
                if (spur_req) begin
                    pa_en_out = 1'b1;
                    pa_new_a  = rand_wide();
                    spur_req  = 0;
                end
                if (pend) begin
                    if (pa_a !== held) stab_bad = 1;
                    if (mcyc == due) begin
                        pa_en_out = 1'b1;
                        pa_new_a  = resp;
                        pend      = 0;
                    end
                end
                if (pa_en === 1'b1) begin
                    if (prev_en) pulse_bad = 1;
                    launches++;
                    held = pa_a;
                    if (mode != 3) begin
                        pend = 1;
                        due  = mcyc + lat;
                        resp = f(pa_a, mode, key);
                    end
                end
                prev_en = (pa_en === 1'b1);
            end
        end
    end

    // Reference: the result is f applied once per round unless the first completion
    // falls outside the TIMEOUT+1 wait cycles, in which case a_in comes back with err.
    function automatic bit ref_timeout(input int r);
        return (r != 0) && ((mode == 3) || (lat > int'(TIMEOUT) + 1));
    endfunction

    function automatic logic [SIZE-1:0] ref_res(input logic [SIZE-1:0] a, input int r);
        logic [SIZE-1:0] v;
        v = a;
        if (ref_timeout(r)) return a;
        for (int i = 0; i < r; i++) v = f(v, mode, key);
        return v;
    endfunction

    // Cycles from the accept cycle to the first res_valid cycle.
    function automatic int ref_cycles(input int r);
        if (r == 0) return 1;
        if (ref_timeout(r)) return 1 + (int'(TIMEOUT) + 1) + 1;
        return r * (lat + 2);
    endfunction

    function automatic int ref_launches(input int r);
        if (r == 0) return 0;
        if (ref_timeout(r)) return 1;
        return r;
    endfunction

    task automatic run_op(input logic [SIZE-1:0] a, input int r,
                          output logic [SIZE-1:0] res, output logic err,
                          output int cycles, output bit hung);
        a_in   = a;
        rounds = ROUND_W'(r);
        start  = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        cycles = 1;
        while (res_valid !== 1'b1 && cycles < BUDGET) begin
            @(posedge clk); #1;
            cycles++;
        end
        hung = (res_valid !== 1'b1);
        res  = res_a;
        err  = res_err;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
    endtask

    task automatic check_op(input string name, input logic [SIZE-1:0] a, input int r);
        logic [SIZE-1:0] res;
        logic [SIZE-1:0] exp_res;
        logic            err;
        int              cyc;
        int              l0;
        bit              hung;
        l0 = launches;
        exp_res = ref_res(a, r);
        run_op(a, r, res, err, cyc, hung);
        n_vec++;
        if (hung) begin
            n_err++;
            $display("FAIL %s: no res_valid within %0d cycles", name, BUDGET);
        end
        n_vec++;
        if (res !== exp_res) begin
            n_err++;
            $display("FAIL %s res_a: got %h want %h (low 64 bits)", name, res[63:0],
                     exp_res[63:0]);
        end
        n_vec++;
        if (err !== ref_timeout(r)) begin
            n_err++;
            $display("FAIL %s res_err: got %b want %b", name, err, ref_timeout(r));
        end
        n_vec++;
        if (cyc != ref_cycles(r)) begin
            n_err++;
            $display("FAIL %s latency: got %0d want %0d", name, cyc, ref_cycles(r));
        end
        n_vec++;
        if (launches - l0 != ref_launches(r)) begin
            n_err++;
            $display("FAIL %s pa_en pulses: got %0d want %0d", name, launches - l0,
                     ref_launches(r));
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL reset ready: got %b want 1", ready); end
        n_vec++;
        if (pa_en !== 1'b0) begin n_err++; $display("FAIL reset pa_en: got %b want 0", pa_en); end
        n_vec++;
        if (res_valid !== 1'b0) begin
            n_err++; $display("FAIL reset res_valid: got %b want 0", res_valid);
        end
        n_vec++;
        if (res_err !== 1'b0) begin n_err++; $display("FAIL reset res_err: got %b want 0", res_err); end
        n_vec++;
        if (res_a !== '0) begin n_err++; $display("FAIL reset res_a: got %h want 0", res_a[63:0]); end
        n_vec++;
        if (pa_a !== '0) begin n_err++; $display("FAIL reset pa_a: got %h want 0", pa_a[63:0]); end
    endtask

    task automatic test_single_round();
        logic [SIZE-1:0] a;
        a = {(SIZE / 8){8'h5A}};
        mode = 0; lat = 20;
        check_op("single_round", a, 1);
    endtask

    task automatic test_multi_round();
        mode = 1; lat = $urandom_range(5, 30);
        pulse_bad = 0; stab_bad = 0;
        check_op("multi_round", rand_wide(), 3);
        n_vec++;
        if (pulse_bad) begin n_err++; $display("FAIL multi_round pa_en gap: got none want >=1"); end
        n_vec++;
        if (stab_bad) begin n_err++; $display("FAIL multi_round pa_a stable: got changed want held"); end
    endtask

    task automatic test_random_ops();
        for (int i = 0; i < 8; i++) begin
            mode = 2;
            key  = rand_wide();
            lat  = ($urandom_range(0, 4) == 0) ? $urandom_range(60, 65) : $urandom_range(1, 30);
            pulse_bad = 0;
            check_op("random_op", rand_wide(), $urandom_range(0, 6));
            n_vec++;
            if (pulse_bad) begin n_err++; $display("FAIL random_op pa_en gap: got none want >=1"); end
        end
    endtask

    task automatic test_zero_rounds();
        mode = 0; lat = 5;
        check_op("zero_rounds", rand_wide(), 0);
    endtask

    task automatic test_timeout();
        mode = 3; lat = 5;
        check_op("timeout_none", rand_wide(), 1);
        mode = 0; lat = int'(TIMEOUT) + 1;
        check_op("timeout_same_cycle", rand_wide(), 1);
        mode = 0; lat = int'(TIMEOUT) + 2;
        check_op("timeout_late", rand_wide(), 2);
    endtask

    task automatic test_back_to_back();
        logic [SIZE-1:0] a;
        logic [SIZE-1:0] exp_res;
        int              cyc;
        mode = 0; lat = 4;
        a = rand_wide();
        exp_res = a + SIZE'(1);
        a_in = a; rounds = 1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cyc = 1;
        while (res_valid !== 1'b1 && cyc < BUDGET) begin @(posedge clk); #1; cyc++; end
        n_vec++;
        if (res_valid !== 1'b1) begin n_err++; $display("FAIL backpressure: no res_valid"); end
        for (int i = 0; i < 10; i++) begin
            start = 1'b1; a_in = rand_wide(); rounds = 1;
            @(posedge clk); #1;
            n_vec++;
            if (res_valid !== 1'b1 || res_a !== exp_res || res_err !== 1'b0 || ready !== 1'b0)
            begin
                n_err++;
                $display("FAIL backpressure hold: got v%b e%b r%b a=%h want v1 e0 r0 a=%h",
                         res_valid, res_err, ready, res_a[63:0], exp_res[63:0]);
            end
        end
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready = 1'b0;
        start = 1'b0;
        n_vec++;
        if (ready !== 1'b1 || res_valid !== 1'b0 || pa_en !== 1'b0) begin
            n_err++;
            $display("FAIL release: got ready%b valid%b pa_en%b want 1 0 0", ready, res_valid,
                     pa_en);
        end
        check_op("after_release", rand_wide(), 2);
    endtask

    task automatic test_reset_mid();
        logic [SIZE-1:0] a;
        a = rand_wide();
        mode = 0; lat = 10;
        a_in = a; rounds = 3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // round 2 launches at cycle 13; cycle 16 sits in its wait
        repeat (15) begin @(posedge clk); #1; end
        n_vec++;
        if (pa_a !== a + SIZE'(1)) begin
            n_err++; $display("FAIL mid pa_a round1: got %h want %h", pa_a[63:0], a[63:0] + 64'd1);
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if (pa_en !== 1'b0 || res_valid !== 1'b0 || pa_a !== '0) begin
            n_err++;
            $display("FAIL mid reset async: got pa_en%b valid%b pa_a=%h want 0 0 0", pa_en,
                     res_valid, pa_a[63:0]);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        if (ready !== 1'b1) begin n_err++; $display("FAIL mid ready after release: got %b want 1", ready); end
        spur_req = 1;
        repeat (4) begin @(posedge clk); #1; end
        n_vec++;
        if (ready !== 1'b1 || res_valid !== 1'b0 || pa_a !== '0 || res_a !== '0 || pa_en !== 1'b0)
        begin
            n_err++;
            $display("FAIL spurious pa_en_out: got ready%b valid%b pa_a=%h res_a=%h want 1 0 0 0",
                     ready, res_valid, pa_a[63:0], res_a[63:0]);
        end
        check_op("after_reset", rand_wide(), 2);
    endtask

    initial begin
        test_reset();
        test_single_round();
        test_multi_round();
        test_zero_rounds();
        test_timeout();
        test_back_to_back();
        test_random_ops();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
